// File: rtl/rob_pkg.sv
// Shared sizing, instruction-class encodings and record layouts for the
// reorder buffer and its entry storage.
package rob_pkg;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned IDX_W = 5;

  typedef enum logic [1:0] {
    WRITE  = 2'b00,
    STORE  = 2'b01,
    BRANCH = 2'b10,
    JUMP   = 2'b11
  } rob_type_e;

  typedef struct packed {
    rob_type_e   typ;
    logic [4:0]  rd;
    logic        is_load;
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] addr;
    logic [1:0]  stype;
    logic        mispredict;
    logic [31:0] target;
  } rob_entry_t;

  typedef struct packed {
    logic        wb_en1;
    logic [4:0]  wb_target1;
    logic [31:0] wb_data1;
    logic        wb_en2;
    logic [4:0]  wb_target2;
    logic [31:0] wb_data2;
    logic        load_en;
    logic        store_en;
    logic [1:0]  store_type;
    logic [31:0] store_addr;
    logic [31:0] store_value;
    logic        branch_en;
    logic [31:0] branch_target;
    logic        jump_en;
    logic [31:0] jump_target;
    logic [31:0] ins_pc;
    logic        flush_en;
  } commit_t;

endpackage

// File: rtl/rob_entry_ram.sv
// ROB entry storage: one allocation port, two completion ports, and read
// ports at head and head+1 (the second exposes only what slot 1 needs).
module rob_entry_ram
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH = rob_pkg::DEPTH,
  parameter int unsigned IDX_W = rob_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             alloc_we_i,
  input  logic [IDX_W-1:0] alloc_idx_i,
  input  rob_type_e        alloc_type_i,
  input  logic [4:0]       alloc_rd_i,
  input  logic             alloc_is_load_i,
  input  logic [31:0]      alloc_pc_i,
  input  logic             c0_we_i,
  input  logic [IDX_W-1:0] c0_idx_i,
  input  logic [31:0]      c0_data_i,
  input  logic [31:0]      c0_addr_i,
  input  logic [1:0]       c0_stype_i,
  input  logic             c0_mispredict_i,
  input  logic [31:0]      c0_target_i,
  input  logic             c1_we_i,
  input  logic [IDX_W-1:0] c1_idx_i,
  input  logic [31:0]      c1_data_i,
  input  logic             clr0_i,
  input  logic             clr1_i,
  input  logic [IDX_W-1:0] rd0_idx_i,
  input  logic [IDX_W-1:0] rd1_idx_i,
  output logic             rd0_valid_o,
  output logic             rd0_done_o,
  output rob_entry_t       rd0_o,
  output logic             rd1_valid_o,
  output logic             rd1_done_o,
  output rob_type_e        rd1_type_o,
  output logic [4:0]       rd1_rd_o,
  output logic [31:0]      rd1_data_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  rob_entry_t       mem_q [DEPTH];
  logic             c0_hit;
  logic             c1_hit;

  // Completions addressed to empty slots are dropped.
  assign c0_hit = c0_we_i && valid_q[c0_idx_i];
  assign c1_hit = c1_we_i && valid_q[c1_idx_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (alloc_we_i) begin
        valid_q[alloc_idx_i] <= 1'b1;
        done_q[alloc_idx_i]  <= 1'b0;
      end
      if (c0_hit) done_q[c0_idx_i] <= 1'b1;
      if (c1_hit) done_q[c1_idx_i] <= 1'b1;
      if (clr0_i) valid_q[rd0_idx_i] <= 1'b0;
      if (clr1_i) valid_q[rd1_idx_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_we_i) begin
      mem_q[alloc_idx_i].typ     <= alloc_type_i;
      mem_q[alloc_idx_i].rd      <= alloc_rd_i;
      mem_q[alloc_idx_i].is_load <= alloc_is_load_i;
      mem_q[alloc_idx_i].pc      <= alloc_pc_i;
    end
    if (c0_hit) begin
      mem_q[c0_idx_i].data       <= c0_data_i;
      mem_q[c0_idx_i].addr       <= c0_addr_i;
      mem_q[c0_idx_i].stype      <= c0_stype_i;
      mem_q[c0_idx_i].mispredict <= c0_mispredict_i;
      mem_q[c0_idx_i].target     <= c0_target_i;
    end
    if (c1_hit) mem_q[c1_idx_i].data <= c1_data_i;
  end

  assign rd0_valid_o = valid_q[rd0_idx_i];
  assign rd0_done_o  = done_q[rd0_idx_i];
  assign rd0_o       = mem_q[rd0_idx_i];
  assign rd1_valid_o = valid_q[rd1_idx_i];
  assign rd1_done_o  = done_q[rd1_idx_i];
  assign rd1_type_o  = mem_q[rd1_idx_i].typ;
  assign rd1_rd_o    = mem_q[rd1_idx_i].rd;
  assign rd1_data_o  = mem_q[rd1_idx_i].data;

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer with in-order dual retire; drives the registered commit bus
// (writeback, store, branch/jump, flush) and dispatch back-pressure.
module rob_commit
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH = rob_pkg::DEPTH,
  parameter int unsigned IDX_W = rob_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [1:0]       alloc_type,
  input  logic [4:0]       alloc_rd,
  input  logic             alloc_is_load,
  input  logic [31:0]      alloc_pc,
  output logic [IDX_W-1:0] alloc_tag,
  input  logic             cmp0_valid,
  input  logic [IDX_W-1:0] cmp0_tag,
  input  logic [31:0]      cmp0_data,
  input  logic [31:0]      cmp0_addr,
  input  logic [1:0]       cmp0_stype,
  input  logic             cmp0_mispredict,
  input  logic [31:0]      cmp0_target,
  input  logic             cmp1_valid,
  input  logic [IDX_W-1:0] cmp1_tag,
  input  logic [31:0]      cmp1_data,
  output logic             WB_en1,
  output logic [4:0]       WB_target1,
  output logic [31:0]      WB_data1,
  output logic             WB_en2,
  output logic [4:0]       WB_target2,
  output logic [31:0]      WB_data2,
  output logic             load_en,
  output logic             store_en,
  output logic [1:0]       store_type,
  output logic [31:0]      store_addr,
  output logic [31:0]      store_value,
  output logic             branch_en,
  output logic [31:0]      branch_target_pc,
  output logic             jump_en,
  output logic [31:0]      jump_target_pc,
  output logic [31:0]      ins_pc,
  output logic             flush_en,
  output logic             rob_full
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [IDX_W-1:0] head_q, head_d, head_nxt;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  commit_t          commit_q, commit_d;

  logic             e0_valid, e0_done, e1_valid, e1_done;
  rob_entry_t       e0;
  rob_type_e        e1_type;
  logic [4:0]       e1_rd;
  logic [31:0]      e1_data;
  logic             ret0, ret1, mis, alloc_fire;
  logic [1:0]       n_ret;

  assign head_nxt    = head_q + IDX_W'(1);
  assign rob_full    = (count_q == CNT_W'(DEPTH));
  assign alloc_ready = !rob_full && !commit_q.flush_en;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail_q;

  rob_entry_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (mis),
    .alloc_we_i      (alloc_fire && !mis),
    .alloc_idx_i     (tail_q),
    .alloc_type_i    (rob_type_e'(alloc_type)),
    .alloc_rd_i      (alloc_rd),
    .alloc_is_load_i (alloc_is_load),
    .alloc_pc_i      (alloc_pc),
    .c0_we_i         (cmp0_valid && !mis),
    .c0_idx_i        (cmp0_tag),
    .c0_data_i       (cmp0_data),
    .c0_addr_i       (cmp0_addr),
    .c0_stype_i      (cmp0_stype),
    .c0_mispredict_i (cmp0_mispredict),
    .c0_target_i     (cmp0_target),
    .c1_we_i         (cmp1_valid && !mis),
    .c1_idx_i        (cmp1_tag),
    .c1_data_i       (cmp1_data),
    .clr0_i          (ret0),
    .clr1_i          (ret1),
    .rd0_idx_i       (head_q),
    .rd1_idx_i       (head_nxt),
    .rd0_valid_o     (e0_valid),
    .rd0_done_o      (e0_done),
    .rd0_o           (e0),
    .rd1_valid_o     (e1_valid),
    .rd1_done_o      (e1_done),
    .rd1_type_o      (e1_type),
    .rd1_rd_o        (e1_rd),
    .rd1_data_o      (e1_data)
  );

  // Stores, branches and jumps always retire alone in slot 0.
  assign ret0  = e0_valid && e0_done;
  assign ret1  = ret0 && (e0.typ == WRITE) && e1_valid && e1_done && (e1_type == WRITE);
  assign mis   = ret0 && ((e0.typ == BRANCH) || (e0.typ == JUMP)) && e0.mispredict;
  assign n_ret = {1'b0, ret0} + {1'b0, ret1};

  always_comb begin
    commit_d = '0;
    if (ret0) begin
      commit_d.ins_pc   = e0.pc;
      commit_d.flush_en = mis;
      unique case (e0.typ)
        WRITE: begin
          commit_d.wb_en1     = (e0.rd != 5'd0);
          commit_d.wb_target1 = e0.rd;
          commit_d.wb_data1   = e0.data;
          commit_d.load_en    = e0.is_load;
        end
        STORE: begin
          commit_d.store_en    = 1'b1;
          commit_d.store_type  = e0.stype;
          commit_d.store_addr  = e0.addr;
          commit_d.store_value = e0.data;
        end
        BRANCH: begin
          commit_d.branch_en     = 1'b1;
          commit_d.branch_target = e0.target;
        end
        JUMP: begin
          commit_d.jump_en     = 1'b1;
          commit_d.jump_target = e0.target;
          commit_d.wb_en1      = (e0.rd != 5'd0);
          commit_d.wb_target1  = e0.rd;
          commit_d.wb_data1    = e0.pc + 32'd4;
        end
      endcase
    end
    if (ret1) begin
      commit_d.wb_en2     = (e1_rd != 5'd0);
      commit_d.wb_target2 = e1_rd;
      commit_d.wb_data2   = e1_data;
    end
  end

  always_comb begin
    head_d  = head_q + IDX_W'(n_ret);
    tail_d  = tail_q + IDX_W'(alloc_fire);
    count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(n_ret);
    // A mispredict empties the ROB just past the retiring branch/jump.
    if (mis) begin
      head_d  = head_nxt;
      tail_d  = head_nxt;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      commit_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      commit_q <= commit_d;
    end
  end

  assign WB_en1           = commit_q.wb_en1;
  assign WB_target1       = commit_q.wb_target1;
  assign WB_data1         = commit_q.wb_data1;
  assign WB_en2           = commit_q.wb_en2;
  assign WB_target2       = commit_q.wb_target2;
  assign WB_data2         = commit_q.wb_data2;
  assign load_en          = commit_q.load_en;
  assign store_en         = commit_q.store_en;
  assign store_type       = commit_q.store_type;
  assign store_addr       = commit_q.store_addr;
  assign store_value      = commit_q.store_value;
  assign branch_en        = commit_q.branch_en;
  assign branch_target_pc = commit_q.branch_target;
  assign jump_en          = commit_q.jump_en;
  assign jump_target_pc   = commit_q.jump_target;
  assign ins_pc           = commit_q.ins_pc;
  assign flush_en         = commit_q.flush_en;

  a_cmp_tag_distinct: assert property (@(posedge clk) disable iff (!rst_n)
    !(cmp0_valid && cmp1_valid && (cmp0_tag == cmp1_tag)));

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: ordered dual retire, full/wrap, store
// isolation, mispredict flush, jump link value and mid-flight reset.
module tb_rob_commit;

  logic        clk, rst_n;
  logic        alloc_valid, alloc_ready, alloc_is_load;
  logic [1:0]  alloc_type;
  logic [4:0]  alloc_rd;
  logic [31:0] alloc_pc;
  logic [4:0]  alloc_tag;
  logic        cmp0_valid, cmp0_mispredict;
  logic [4:0]  cmp0_tag;
  logic [31:0] cmp0_data, cmp0_addr, cmp0_target;
  logic [1:0]  cmp0_stype;
  logic        cmp1_valid;
  logic [4:0]  cmp1_tag;
  logic [31:0] cmp1_data;
  logic        WB_en1, WB_en2, load_en, store_en, branch_en, jump_en, flush_en, rob_full;
  logic [4:0]  WB_target1, WB_target2;
  logic [31:0] WB_data1, WB_data2, store_addr, store_value;
  logic [31:0] branch_target_pc, jump_target_pc, ins_pc;
  logic [1:0]  store_type;

  int errors = 0;
  int checks = 0;

  rob_commit dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_type(alloc_type),
    .alloc_rd(alloc_rd), .alloc_is_load(alloc_is_load), .alloc_pc(alloc_pc),
    .alloc_tag(alloc_tag),
    .cmp0_valid(cmp0_valid), .cmp0_tag(cmp0_tag), .cmp0_data(cmp0_data),
    .cmp0_addr(cmp0_addr), .cmp0_stype(cmp0_stype), .cmp0_mispredict(cmp0_mispredict),
    .cmp0_target(cmp0_target),
    .cmp1_valid(cmp1_valid), .cmp1_tag(cmp1_tag), .cmp1_data(cmp1_data),
    .WB_en1(WB_en1), .WB_target1(WB_target1), .WB_data1(WB_data1),
    .WB_en2(WB_en2), .WB_target2(WB_target2), .WB_data2(WB_data2),
    .load_en(load_en), .store_en(store_en), .store_type(store_type),
    .store_addr(store_addr), .store_value(store_value),
    .branch_en(branch_en), .branch_target_pc(branch_target_pc),
    .jump_en(jump_en), .jump_target_pc(jump_target_pc),
    .ins_pc(ins_pc), .flush_en(flush_en), .rob_full(rob_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic do_alloc(input logic [1:0] t, input logic [4:0] rd,
                          input logic ld, input logic [31:0] pc);
    alloc_valid = 1'b1; alloc_type = t; alloc_rd = rd; alloc_is_load = ld; alloc_pc = pc;
    step();
    alloc_valid = 1'b0; alloc_is_load = 1'b0;
  endtask

  task automatic drive_cmp0(input logic [4:0] tag, input logic [31:0] data,
                            input logic [31:0] addr, input logic [1:0] st,
                            input logic mp, input logic [31:0] tgt);
    cmp0_valid = 1'b1; cmp0_tag = tag; cmp0_data = data; cmp0_addr = addr;
    cmp0_stype = st; cmp0_mispredict = mp; cmp0_target = tgt;
  endtask

  task automatic drive_cmp1(input logic [4:0] tag, input logic [31:0] data);
    cmp1_valid = 1'b1; cmp1_tag = tag; cmp1_data = data;
  endtask

  task automatic idle_cmp();
    cmp0_valid = 1'b0; cmp0_mispredict = 1'b0; cmp1_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    alloc_valid = 1'b0; alloc_type = 2'b00; alloc_rd = '0; alloc_is_load = 1'b0; alloc_pc = '0;
    cmp0_valid = 1'b0; cmp0_tag = '0; cmp0_data = '0; cmp0_addr = '0; cmp0_stype = '0;
    cmp0_mispredict = 1'b0; cmp0_target = '0;
    cmp1_valid = 1'b0; cmp1_tag = '0; cmp1_data = '0;
    #2;
    check_eq("rst_wb1", WB_en1, 0);
    check_eq("rst_full", rob_full, 0);
    check_eq("rst_ready", alloc_ready, 1);
    check_eq("rst_tag", alloc_tag, 0);
    check_eq("rst_flush", flush_en, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Four writes completed out of order, retired in pairs.
    for (int i = 0; i < 4; i++)
      do_alloc(2'b00, 5'(i + 1), (i == 0), 32'h1000 + 32'(4 * i));
    check_eq("s1_tag", alloc_tag, 4);
    drive_cmp1(5'd3, 32'h103); step(); idle_cmp();
    check_eq("s1_wait3", WB_en1, 0);
    drive_cmp0(5'd2, 32'h102, 0, 0, 0, 0); step(); idle_cmp();
    check_eq("s1_wait2", WB_en1, 0);
    drive_cmp1(5'd1, 32'h101); step(); idle_cmp();
    check_eq("s1_wait1", WB_en1, 0);
    drive_cmp0(5'd0, 32'h100, 0, 0, 0, 0); step(); idle_cmp();
    check_eq("s1_nobypass", WB_en1, 0);
    step();
    check_eq("s1_p0_en1", WB_en1, 1);
    check_eq("s1_p0_t1", WB_target1, 1);
    check_eq("s1_p0_d1", WB_data1, 32'h100);
    check_eq("s1_p0_en2", WB_en2, 1);
    check_eq("s1_p0_t2", WB_target2, 2);
    check_eq("s1_p0_d2", WB_data2, 32'h101);
    check_eq("s1_p0_pc", ins_pc, 32'h1000);
    check_eq("s1_p0_load", load_en, 1);
    step();
    check_eq("s1_p1_en1", WB_en1, 1);
    check_eq("s1_p1_t1", WB_target1, 3);
    check_eq("s1_p1_d1", WB_data1, 32'h102);
    check_eq("s1_p1_t2", WB_target2, 4);
    check_eq("s1_p1_d2", WB_data2, 32'h103);
    check_eq("s1_p1_pc", ins_pc, 32'h1008);
    check_eq("s1_p1_load", load_en, 0);
    step();
    check_eq("s1_pulse", WB_en1, 0);

    // Fill, refuse while full, retire one, wrap.
    apply_reset();
    for (int i = 0; i < 32; i++)
      do_alloc(2'b00, 5'd5, 1'b0, 32'h4000 + 32'(4 * i));
    check_eq("s2_full", rob_full, 1);
    check_eq("s2_ready", alloc_ready, 0);
    check_eq("s2_wrap", alloc_tag, 0);
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    drive_cmp1(5'd0, 32'h55); step(); idle_cmp();
    check_eq("s2_refuse_tag", alloc_tag, 0);
    check_eq("s2_still_full", rob_full, 1);
    step();
    check_eq("s2_ret_wb", WB_en1, 1);
    check_eq("s2_ret_data", WB_data1, 32'h55);
    check_eq("s2_notfull", rob_full, 0);
    check_eq("s2_ready1", alloc_ready, 1);
    check_eq("s2_same_cycle", alloc_tag, 0);
    step();
    alloc_valid = 1'b0;
    check_eq("s2_refill_tag", alloc_tag, 1);
    check_eq("s2_refull", rob_full, 1);

    // Write followed by store: never paired.
    apply_reset();
    do_alloc(2'b00, 5'd9, 1'b0, 32'h2000);
    do_alloc(2'b01, 5'd0, 1'b0, 32'h2004);
    drive_cmp1(5'd0, 32'h77);
    drive_cmp0(5'd1, 32'hDEAD, 32'h100, 2'd2, 0, 0);
    step(); idle_cmp();
    step();
    check_eq("s3_wb", WB_en1, 1);
    check_eq("s3_wbt", WB_target1, 9);
    check_eq("s3_wbd", WB_data1, 32'h77);
    check_eq("s3_nopair", WB_en2, 0);
    check_eq("s3_nostore", store_en, 0);
    step();
    check_eq("s3_st_en", store_en, 1);
    check_eq("s3_st_type", store_type, 2);
    check_eq("s3_st_addr", store_addr, 32'h100);
    check_eq("s3_st_val", store_value, 32'hDEAD);
    check_eq("s3_st_wb", WB_en1, 0);
    check_eq("s3_st_pc", ins_pc, 32'h2004);
    step();
    check_eq("s3_st_pulse", store_en, 0);

    // Mispredicted branch ahead of three completed writes.
    apply_reset();
    do_alloc(2'b10, 5'd0, 1'b0, 32'h3000);
    for (int i = 0; i < 3; i++)
      do_alloc(2'b00, 5'(10 + i), 1'b0, 32'h3004 + 32'(4 * i));
    drive_cmp0(5'd1, 32'hA1, 0, 0, 0, 0);
    drive_cmp1(5'd2, 32'hA2);
    step(); idle_cmp();
    drive_cmp1(5'd3, 32'hA3); step(); idle_cmp();
    check_eq("s4_blocked", WB_en1, 0);
    drive_cmp0(5'd0, 0, 0, 0, 1'b1, 32'h80); step(); idle_cmp();
    check_eq("s4_br_early", branch_en, 0);
    check_eq("s4_tag_pre", alloc_tag, 4);
    alloc_valid = 1'b1; alloc_type = 2'b00; alloc_rd = 5'd13;
    step();
    alloc_valid = 1'b0;
    check_eq("s4_br_en", branch_en, 1);
    check_eq("s4_flush", flush_en, 1);
    check_eq("s4_br_tgt", branch_target_pc, 32'h80);
    check_eq("s4_nowb", WB_en1, 0);
    check_eq("s4_nowb2", WB_en2, 0);
    check_eq("s4_ready0", alloc_ready, 0);
    check_eq("s4_tail", alloc_tag, 1);
    check_eq("s4_pc", ins_pc, 32'h3000);
    step();
    check_eq("s4_flush_pulse", flush_en, 0);
    check_eq("s4_ready1", alloc_ready, 1);
    check_eq("s4_after_wb", WB_en1, 0);
    drive_cmp1(5'd2, 32'hBB); step(); idle_cmp();
    step();
    check_eq("s4_dropped", WB_en1, 0);
    check_eq("s4_tail2", alloc_tag, 1);

    // Jump with link register.
    do_alloc(2'b11, 5'd1, 1'b0, 32'h40);
    drive_cmp0(5'd1, 32'h999, 0, 0, 1'b0, 32'h200); step(); idle_cmp();
    step();
    check_eq("s5_jmp_en", jump_en, 1);
    check_eq("s5_jmp_tgt", jump_target_pc, 32'h200);
    check_eq("s5_link_en", WB_en1, 1);
    check_eq("s5_link_rd", WB_target1, 1);
    check_eq("s5_link_val", WB_data1, 32'h44);
    check_eq("s5_noflush", flush_en, 0);
    check_eq("s5_pc", ins_pc, 32'h40);

    // Reset with ten entries in flight while a retire is on the bus.
    for (int i = 0; i < 10; i++)
      do_alloc(2'b00, 5'(20 + i), 1'b0, 32'h5000 + 32'(4 * i));
    drive_cmp0(5'd4, 32'hC4, 0, 0, 0, 0);
    drive_cmp1(5'd5, 32'hC5);
    step(); idle_cmp();
    drive_cmp0(5'd2, 32'hC2, 0, 0, 0, 0);
    drive_cmp1(5'd3, 32'hC3);
    step(); idle_cmp();
    step();
    check_eq("s6_pre_wb1", WB_en1, 1);
    check_eq("s6_pre_wb2", WB_en2, 1);
    rst_n = 1'b0;
    #1;
    check_eq("s6_rst_wb1", WB_en1, 0);
    check_eq("s6_rst_wb2", WB_en2, 0);
    check_eq("s6_rst_pc", ins_pc, 0);
    check_eq("s6_rst_tag", alloc_tag, 0);
    check_eq("s6_rst_ready", alloc_ready, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("s6_noretire", {WB_en1, WB_en2}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer and in-order retire stage of the out-of-order RISC-V core. It allocates entries in program order from dispatch and marks them done from the two execution completion ports. It retires up to two entries per cycle and drives the registered commit bus (writeback, store, branch/jump, flush, ROB-full) that feeds the commit checker directly downstream.

## Interface
- DEPTH, 32, ROB entries (power of two)
- IDX_W, 5, log2(DEPTH); tag width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alloc_valid  in  1  dispatch offers one instruction
- alloc_ready  out  1  = !rob_full && !flush_en
- alloc_type  in  2  00 write, 01 store, 10 branch, 11 jump
- alloc_rd / alloc_is_load / alloc_pc  in  5/1/32  destination, load flag, PC
- alloc_tag  out  IDX_W  tail index handed to dispatch
- cmp0_valid, cmp0_tag  in  1, IDX_W  full-function completion port
- cmp0_data, cmp0_addr  in  32, 32  result/store value; store address
- cmp0_stype, cmp0_mispredict, cmp0_target  in  2, 1, 32  store size; mispredict; resolved target
- cmp1_valid, cmp1_tag, cmp1_data  in  1, IDX_W, 32  ALU-only completion port
- WB_en1/2, WB_target1/2, WB_data1/2  out  1, 5, 32  retired register writes (slot 0/1)
- load_en  out  1  slot-0 write came from a load
- store_en, store_type, store_addr, store_value  out  1, 2, 32, 32
- branch_en, branch_target_pc, jump_en, jump_target_pc  out  1, 32, 1, 32
- ins_pc  out  32  PC of slot-0 retired entry
- flush_en  out  1  mispredicted branch/jump retired
- rob_full  out  1  count == DEPTH (combinational from state)

## Operation
- State: head, tail (IDX_W, wrap modulo DEPTH), count (IDX_W+1); per entry: valid, done, type, rd, is_load, pc, data, addr, stype, mispredict, target.
- Alloc when alloc_valid && alloc_ready: entry[tail] written with done=0; tail+1, count+1.
- Completion: cmp0/cmp1 set done and payload of entry[tag]; tag to an invalid entry is ignored. Same tag on both ports in one cycle is illegal (assertion).
- Slot 0 retires entry[head] if valid && done. Write type: WB_en1 = (rd != 0), load_en = is_load. Store: store_en only. Branch: branch_en, branch_target_pc = target. Jump: jump_en, jump_target_pc = target, plus WB_en1 with pc+4 when rd != 0.
- Slot 1 retires entry[head+1] only if slot 0 retires a write type, entry[head+1] is a write type, valid and done. Drives WB_en2 (if rd != 0). Stores, branches and jumps retire alone in slot 0.
- rd == 0 writes retire (head advances) with WB_en deasserted.
- Mispredict: slot-0 branch/jump with mispredict=1 asserts flush_en with branch_en/jump_en. At the same edge all valid bits clear, tail = head+1, count = 0, and alloc/completion in that cycle are discarded.
- Simultaneous alloc and retire: count += 1 − retired. Full with a retire in the same cycle still refuses alloc, because alloc_ready is based on the current count.

## Timing
- Reset (async, rst_n low): head = tail = count = 0, all valid = 0, all commit outputs 0, rob_full = 0, alloc_ready = 1. Reset mid-flight drops every entry.
- Commit outputs are registered and pulse for exactly one cycle per retire.
- Completion sampled at edge E → earliest retire decision at edge E+1 → outputs high during the cycle after E+1. There is no completion-to-commit bypass.
- Alloc sampled at edge E → entry visible to completion from the cycle after E.
- flush_en and alloc_ready = 0 hold for one cycle. The ROB is empty from the next edge.

## Structure
- Shared package rob_pkg: DEPTH/IDX_W, type encodings (WRITE=2'b00, STORE=2'b01, BRANCH=2'b10, JUMP=2'b11), entry struct.
- One sub-module rob_entry_ram: DEPTH-entry storage with one write port (alloc), two completion write ports and two read ports (head, head+1).
- Retire selection, pointers and output registers live in rob_commit.

## Test plan
- Reset, then alloc 4 writes (rd 1..4), complete in order 4,3,2,1 → no retire until tag 0 is done; then WB pairs (1,2), (3,4) over two consecutive cycles; ins_pc = PC of rd 1, then rd 3.
- Alloc 32 entries → rob_full = 1 and alloc_ready = 0; retire one → rob_full drops the cycle after the retire edge; tail wraps to 0.
- Write then store (addr 0x100, value 0xDEAD, type 2) → write retires alone, store_en next cycle with exact payload, never paired.
- Branch with mispredict=1, target 0x80, followed by 3 done writes → branch_en and flush_en, branch_target_pc = 0x80; no WB for the younger writes; count = 0.
- Jump rd = 1 at PC 0x40, target 0x200 → jump_en, jump_target_pc = 0x200, WB_en1 with WB_data1 = 0x44.
- Assert rst_n low with 10 entries in flight → every output 0 immediately; no retire after release.
